// File: rtl/vc_input_buffer.sv
// Per-VC input FIFOs with downstream credit tracking and a packet-locking
// round-robin arbiter that forwards one flit per cycle.
module vc_input_buffer #(
  parameter int unsigned flit_size     = 30,
  parameter int unsigned num_of_vcs    = 2,
  parameter int unsigned vcs_size      = 2,
  parameter int unsigned buffer_addr_w = 2,
  parameter int unsigned down_credits  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [flit_size-1:0]  in_port,
  input  logic                  write,
  output logic [num_of_vcs-1:0] out_credit,
  output logic [flit_size-1:0]  out_port,
  output logic                  out_write,
  input  logic [num_of_vcs-1:0] in_credit,
  output logic                  overflow
);

  localparam int unsigned DEPTH    = 1 << buffer_addr_w;
  localparam int unsigned CNT_W    = buffer_addr_w + 1;
  localparam int unsigned DC_W     = $clog2(down_credits + 1);
  localparam int unsigned CRED_W   = (DC_W > CNT_W) ? DC_W : CNT_W;
  localparam int unsigned VC_W     = (num_of_vcs > 1) ? $clog2(num_of_vcs) : 1;
  localparam int unsigned TAIL_BIT = 8;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state, state_nxt;
  logic [VC_W-1:0] lock_vc, lock_vc_nxt;
  logic [VC_W-1:0] rr_ptr;

  logic [flit_size-1:0]     mem    [num_of_vcs][DEPTH];
  logic [buffer_addr_w-1:0] rd_ptr [num_of_vcs];
  logic [buffer_addr_w-1:0] wr_ptr [num_of_vcs];
  logic [CNT_W-1:0]         count  [num_of_vcs];
  logic [CRED_W-1:0]        credit [num_of_vcs];

  logic [num_of_vcs-1:0] elig_c;
  logic [num_of_vcs-1:0] pop_c;
  logic [num_of_vcs-1:0] push_c;
  logic                  grant_c;
  logic [VC_W-1:0]       grant_vc_c;
  logic [flit_size-1:0]  head_flit_c;
  logic [vcs_size-1:0]   wr_vc_c;
  logic                  wr_in_range_c;
  logic                  wr_drop_c;

  // A VC can be served when it has a flit and the downstream has room for it
  always_comb begin
    elig_c = '0;
    for (int unsigned v = 0; v < num_of_vcs; v++)
      elig_c[v] = (count[v] != '0) && (credit[v] != '0);
  end

  // Arbiter state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lock_vc <= '0;
    end else begin
      state   <= state_nxt;
      lock_vc <= lock_vc_nxt;
    end
  end

  // Grant selection: locked VC only, else first eligible VC from rr_ptr
  always_comb begin
    grant_c     = 1'b0;
    grant_vc_c  = '0;
    pop_c       = '0;
    if (state == LOCKED) begin
      grant_c    = elig_c[lock_vc];
      grant_vc_c = lock_vc;
    end else begin
      for (int unsigned i = 0; i < num_of_vcs; i++) begin
        if (!grant_c && elig_c[VC_W'((32'(rr_ptr) + i) % num_of_vcs)]) begin
          grant_c    = 1'b1;
          grant_vc_c = VC_W'((32'(rr_ptr) + i) % num_of_vcs);
        end
      end
    end
    head_flit_c = mem[grant_vc_c][rd_ptr[grant_vc_c]];
    if (grant_c)
      pop_c[grant_vc_c] = 1'b1;
  end

  // A sent flit without tail keeps the link on that VC until the tail goes out
  always_comb begin
    state_nxt   = state;
    lock_vc_nxt = lock_vc;
    if (grant_c) begin
      lock_vc_nxt = grant_vc_c;
      state_nxt   = head_flit_c[TAIL_BIT] ? IDLE : LOCKED;
    end
  end

  // A write to a full FIFO is accepted if that FIFO pops in the same cycle
  always_comb begin
    wr_vc_c       = in_port[vcs_size-1:0];
    wr_in_range_c = 32'(wr_vc_c) < num_of_vcs;
    push_c        = '0;
    for (int unsigned v = 0; v < num_of_vcs; v++)
      push_c[v] = write && wr_in_range_c && (32'(wr_vc_c) == v) &&
                  ((count[v] != CNT_W'(DEPTH)) || pop_c[v]);
    wr_drop_c = write && (push_c == '0);
  end

  always_ff @(posedge clk) begin
    for (int unsigned v = 0; v < num_of_vcs; v++)
      if (!rst && push_c[v])
        mem[v][wr_ptr[v]] <= in_port;
  end

  // Pointers, occupancy, credits and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      out_port   <= '0;
      out_write  <= 1'b0;
      out_credit <= '0;
      overflow   <= 1'b0;
      for (int unsigned v = 0; v < num_of_vcs; v++) begin
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        count[v]  <= '0;
        credit[v] <= CRED_W'(down_credits);
      end
    end else begin
      out_write  <= grant_c;
      out_credit <= pop_c;
      if (grant_c) begin
        out_port <= head_flit_c;
        rr_ptr   <= (grant_vc_c == VC_W'(num_of_vcs - 1)) ? '0 : grant_vc_c + VC_W'(1);
      end
      if (wr_drop_c)
        overflow <= 1'b1;
      for (int unsigned v = 0; v < num_of_vcs; v++) begin
        if (push_c[v])
          wr_ptr[v] <= wr_ptr[v] + buffer_addr_w'(1);
        if (pop_c[v])
          rd_ptr[v] <= rd_ptr[v] + buffer_addr_w'(1);
        count[v] <= count[v] + CNT_W'(push_c[v]) - CNT_W'(pop_c[v]);
        if (pop_c[v] && !in_credit[v])
          credit[v] <= credit[v] - CRED_W'(1);
        else if (in_credit[v] && !pop_c[v] && (credit[v] != CRED_W'(down_credits)))
          credit[v] <= credit[v] + CRED_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vc_input_buffer.sv
// Bench for vc_input_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_vc_input_buffer;

  localparam int NV    = 2;
  localparam int DEPTH = 4;
  localparam int DC    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] in_port;
  logic        write;
  logic [1:0]  in_credit;
  logic [1:0]  out_credit;
  logic [29:0] out_port;
  logic        out_write;
  logic        overflow;

  logic [29:0] in_port1;
  logic        write1;
  logic [1:0]  in_credit1;
  logic [1:0]  out_credit1;
  logic [29:0] out_port1;
  logic        out_write1;
  logic        overflow1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vc_input_buffer dut (
    .clk(clk), .rst(rst), .in_port(in_port), .write(write),
    .out_credit(out_credit), .out_port(out_port), .out_write(out_write),
    .in_credit(in_credit), .overflow(overflow)
  );

  vc_input_buffer #(.down_credits(1)) dut1 (
    .clk(clk), .rst(rst), .in_port(in_port1), .write(write1),
    .out_credit(out_credit1), .out_port(out_port1), .out_write(out_write1),
    .in_credit(in_credit1), .overflow(overflow1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [29:0] mk(input int vc, input bit h, input bit t, input int d);
    mk = {20'(d), h, t, 6'b0, 2'(vc)};
  endfunction

  // Reference model: per-VC queues, integer credits, packet lock
  logic [29:0] mq [NV][$];
  int          mcred [NV];
  int          mrr;
  bit          mlock;
  int          mlvc;
  logic [29:0] e_port = '0;
  logic        e_write = 1'b0;
  logic [1:0]  e_credit = '0;
  logic        e_ovf = 1'b0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin : model
    int g;
    int v;
    logic [29:0] f;
    if (rst) begin
      for (int i = 0; i < NV; i++) begin
        mq[i].delete();
        mcred[i] = DC;
      end
      mrr = 0; mlock = 1'b0; mlvc = 0;
      e_port = '0; e_write = 1'b0; e_credit = '0; e_ovf = 1'b0;
      m_valid = 1'b1;
    end else begin
      g = -1;
      if (mlock) begin
        if (mq[mlvc].size() > 0 && mcred[mlvc] > 0) g = mlvc;
      end else begin
        for (int i = 0; i < NV; i++) begin
          v = (mrr + i) % NV;
          if (g < 0 && mq[v].size() > 0 && mcred[v] > 0) g = v;
        end
      end
      e_write  = (g >= 0);
      e_credit = '0;
      if (g >= 0) begin
        f = mq[g].pop_front();
        e_port = f;
        e_credit[g] = 1'b1;
        mcred[g] = mcred[g] - 1;
        mrr = (g + 1) % NV;
        mlock = !f[8];
        mlvc = g;
      end
      if (write) begin
        v = int'(in_port[1:0]);
        if (v >= NV || mq[v].size() >= DEPTH) e_ovf = 1'b1;
        else mq[v].push_back(in_port);
      end
      for (int i = 0; i < NV; i++)
        if (in_credit[i]) mcred[i] = (mcred[i] + 1 > DC) ? DC : mcred[i] + 1;
    end
  end

  always @(negedge clk) begin : compare
    if (m_valid) begin
      chk("out_write", 64'(out_write), 64'(e_write));
      chk("out_credit", 64'(out_credit), 64'(e_credit));
      chk("out_port", 64'(out_port), 64'(e_port));
      chk("overflow", 64'(overflow), 64'(e_ovf));
    end
  end

  task automatic step(input logic w, input logic [29:0] f, input logic [1:0] c);
    write = w; in_port = f; in_credit = c;
    write1 = 1'b0; in_port1 = '0; in_credit1 = '0;
    @(negedge clk);
  endtask

  task automatic step1(input logic w, input logic [29:0] f, input logic [1:0] c);
    write = 1'b0; in_port = '0; in_credit = '0;
    write1 = w; in_port1 = f; in_credit1 = c;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; write = 1'b0; in_port = '0; in_credit = '0;
    write1 = 1'b0; in_port1 = '0; in_credit1 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_write", 64'(out_write), 64'(0));
    chk("rst_out_credit", 64'(out_credit), 64'(0));
    chk("rst_out_port", 64'(out_port), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_out_write1", 64'(out_write1), 64'(0));
    rst = 1'b0;

    // single head+tail flit: minimum latency
    step(1'b1, mk(0, 1, 1, 'h11), 2'b00);
    chk("lat_edge1_write", 64'(out_write), 64'(0));
    step(1'b0, '0, 2'b00);
    chk("lat_edge2_write", 64'(out_write), 64'(1));
    chk("lat_edge2_credit", 64'(out_credit), 64'(2'b01));
    chk("lat_edge2_port", 64'(out_port), 64'(mk(0, 1, 1, 'h11)));
    step(1'b0, '0, 2'b01);
    chk("lat_edge3_write", 64'(out_write), 64'(0));

    // lock on VC1, VC0 backs up, then round-robin VC0, VC1, VC0
    step(1'b1, mk(1, 1, 0, 'h20), 2'b00);
    step(1'b1, mk(0, 1, 1, 'h21), 2'b00);
    chk("rr_lock_head", 64'(out_port), 64'(mk(1, 1, 0, 'h20)));
    chk("rr_lock_credit", 64'(out_credit), 64'(2'b10));
    step(1'b1, mk(0, 1, 1, 'h22), 2'b00);
    chk("rr_lock_stall_a", 64'(out_write), 64'(0));
    step(1'b1, mk(1, 0, 1, 'h23), 2'b00);
    chk("rr_lock_stall_b", 64'(out_write), 64'(0));
    step(1'b1, mk(1, 1, 1, 'h24), 2'b00);
    chk("rr_lock_tail", 64'(out_port), 64'(mk(1, 0, 1, 'h23)));
    step(1'b0, '0, 2'b00);
    chk("rr_g1_credit", 64'(out_credit), 64'(2'b01));
    chk("rr_g1_port", 64'(out_port), 64'(mk(0, 1, 1, 'h21)));
    step(1'b0, '0, 2'b00);
    chk("rr_g2_credit", 64'(out_credit), 64'(2'b10));
    chk("rr_g2_port", 64'(out_port), 64'(mk(1, 1, 1, 'h24)));
    step(1'b0, '0, 2'b00);
    chk("rr_g3_credit", 64'(out_credit), 64'(2'b01));
    chk("rr_g3_port", 64'(out_port), 64'(mk(0, 1, 1, 'h22)));
    step(1'b0, '0, 2'b11);
    step(1'b0, '0, 2'b11);
    step(1'b0, '0, 2'b10);

    // 3-flit VC0 packet with delayed body; VC1 must wait for the tail
    step(1'b1, mk(0, 1, 0, 'h30), 2'b00);
    step(1'b1, mk(1, 1, 1, 'h31), 2'b00);
    chk("pkt_head", 64'(out_port), 64'(mk(0, 1, 0, 'h30)));
    step(1'b1, mk(1, 1, 1, 'h32), 2'b00);
    chk("pkt_stall1", 64'(out_write), 64'(0));
    step(1'b0, '0, 2'b00);
    chk("pkt_stall2", 64'(out_write), 64'(0));
    step(1'b1, mk(0, 0, 0, 'h33), 2'b00);
    chk("pkt_stall3", 64'(out_write), 64'(0));
    step(1'b1, mk(0, 0, 1, 'h34), 2'b00);
    chk("pkt_body", 64'(out_port), 64'(mk(0, 0, 0, 'h33)));
    step(1'b0, '0, 2'b00);
    chk("pkt_tail", 64'(out_port), 64'(mk(0, 0, 1, 'h34)));
    step(1'b0, '0, 2'b00);
    chk("pkt_vc1_after", 64'(out_port), 64'(mk(1, 1, 1, 'h31)));
    chk("pkt_vc1_credit", 64'(out_credit), 64'(2'b10));
    step(1'b0, '0, 2'b00);
    chk("pkt_vc1_second", 64'(out_port), 64'(mk(1, 1, 1, 'h32)));
    step(1'b0, '0, 2'b11);
    step(1'b0, '0, 2'b11);
    step(1'b0, '0, 2'b01);

    // exhaust VC1 credits, overfill its FIFO, then drain on credit returns
    for (int i = 0; i < 4; i++) step(1'b1, mk(1, 1, 1, 'h40 + i), 2'b00);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, mk(1, 1, 1, 'h50 + i), 2'b00);
      if (i == 3) chk("ovf_full_no_drop", 64'(overflow), 64'(0));
    end
    chk("ovf_set", 64'(overflow), 64'(1));
    chk("ovf_no_send", 64'(out_write), 64'(0));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 2'b10);
      if (i > 0) chk("ovf_drain", 64'(out_port), 64'(mk(1, 1, 1, 'h50 + i - 1)));
    end
    step(1'b0, '0, 2'b00);
    chk("ovf_drain_last", 64'(out_port), 64'(mk(1, 1, 1, 'h53)));
    step(1'b0, '0, 2'b00);
    chk("ovf_drain_done", 64'(out_write), 64'(0));
    chk("ovf_sticky", 64'(overflow), 64'(1));
    for (int i = 0; i < 4; i++) step(1'b0, '0, 2'b10);

    // reset while locked with flits buffered; inputs ignored during reset
    step(1'b1, mk(0, 1, 0, 'h60), 2'b00);
    step(1'b1, mk(1, 1, 1, 'h61), 2'b00);
    chk("mid_head", 64'(out_port), 64'(mk(0, 1, 0, 'h60)));
    step(1'b1, mk(1, 1, 1, 'h62), 2'b00);
    chk("mid_stall", 64'(out_write), 64'(0));
    rst = 1'b1;
    step(1'b1, mk(0, 1, 1, 'h63), 2'b11);
    chk("mid_rst_write", 64'(out_write), 64'(0));
    chk("mid_rst_credit", 64'(out_credit), 64'(0));
    chk("mid_rst_ovf", 64'(overflow), 64'(0));
    chk("mid_rst_port", 64'(out_port), 64'(0));
    rst = 1'b0;
    step(1'b0, '0, 2'b00);
    chk("mid_flushed", 64'(out_write), 64'(0));
    step(1'b1, mk(1, 1, 1, 'h64), 2'b00);
    step(1'b0, '0, 2'b00);
    chk("mid_unlocked", 64'(out_port), 64'(mk(1, 1, 1, 'h64)));
    chk("mid_unlocked_credit", 64'(out_credit), 64'(2'b10));
    step(1'b0, '0, 2'b10);

    // full FIFO accepts a write in the same cycle it pops
    step(1'b1, mk(1, 1, 0, 'h70), 2'b00);
    step(1'b1, mk(0, 1, 1, 'h71), 2'b00);
    for (int i = 0; i < 3; i++) step(1'b1, mk(0, 1, 1, 'h72 + i), 2'b00);
    step(1'b1, mk(1, 0, 1, 'h75), 2'b00);
    step(1'b0, '0, 2'b00);
    chk("full_lock_tail", 64'(out_port), 64'(mk(1, 0, 1, 'h75)));
    step(1'b1, mk(0, 1, 1, 'h76), 2'b00);
    chk("full_pop_push_ovf", 64'(overflow), 64'(0));
    chk("full_pop_push_port", 64'(out_port), 64'(mk(0, 1, 1, 'h71)));
    step(1'b0, '0, 2'b01);
    step(1'b0, '0, 2'b00);
    step(1'b0, '0, 2'b00);
    step(1'b0, '0, 2'b00);
    chk("full_last_out", 64'(out_port), 64'(mk(0, 1, 1, 'h76)));
    step(1'b0, '0, 2'b00);
    chk("full_drained", 64'(out_write), 64'(0));
    step(1'b0, '0, 2'b11);
    step(1'b0, '0, 2'b11);
    step(1'b0, '0, 2'b01);
    step(1'b0, '0, 2'b01);

    // VC field beyond num_of_vcs is dropped with overflow
    step(1'b1, mk(2, 1, 1, 'h80), 2'b00);
    chk("badvc_ovf", 64'(overflow), 64'(1));
    step(1'b0, '0, 2'b00);
    chk("badvc_no_send", 64'(out_write), 64'(0));
    step(1'b1, mk(3, 1, 1, 'h81), 2'b00);
    step(1'b0, '0, 2'b00);
    chk("badvc3_no_send", 64'(out_write), 64'(0));

    // single-credit instance: same-cycle credit return keeps grants flowing
    step1(1'b1, mk(0, 1, 1, 'h90), 2'b00);
    step1(1'b1, mk(0, 1, 1, 'h91), 2'b01);
    chk("c1_g0_write", 64'(out_write1), 64'(1));
    chk("c1_g0_port", 64'(out_port1), 64'(mk(0, 1, 1, 'h90)));
    step1(1'b1, mk(0, 1, 1, 'h92), 2'b01);
    chk("c1_g1_port", 64'(out_port1), 64'(mk(0, 1, 1, 'h91)));
    chk("c1_g1_write", 64'(out_write1), 64'(1));
    step1(1'b0, '0, 2'b01);
    chk("c1_g2_port", 64'(out_port1), 64'(mk(0, 1, 1, 'h92)));
    chk("c1_g2_write", 64'(out_write1), 64'(1));
    step1(1'b1, mk(0, 1, 1, 'h93), 2'b00);
    chk("c1_empty", 64'(out_write1), 64'(0));
    step1(1'b1, mk(0, 1, 1, 'h94), 2'b00);
    chk("c1_g3_port", 64'(out_port1), 64'(mk(0, 1, 1, 'h93)));
    step1(1'b0, '0, 2'b00);
    chk("c1_no_credit", 64'(out_write1), 64'(0));
    step1(1'b0, '0, 2'b01);
    chk("c1_credit_pending", 64'(out_write1), 64'(0));
    step1(1'b0, '0, 2'b00);
    chk("c1_g4_port", 64'(out_port1), 64'(mk(0, 1, 1, 'h94)));
    chk("c1_g4_credit", 64'(out_credit1), 64'(2'b01));
    step1(1'b0, '0, 2'b00);
    chk("c1_idle", 64'(out_write1), 64'(0));
    chk("c1_ovf", 64'(overflow1), 64'(0));

    step(1'b0, '0, 2'b00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vc_input_buffer.md
VC_INPUT_BUFFER -- requirements
Module: vc_input_buffer

Interface
REQ-001 SHALL have parameter flit_size, default 30, flit width in bits.
REQ-002 SHALL have parameter num_of_vcs, default 2, number of virtual channels.
REQ-003 SHALL have parameter vcs_size, default 2, width of VC field at flit[vcs_size-1:0].
REQ-004 SHALL have parameter buffer_addr_w, default 2, log2 of per-VC FIFO depth (depth 4).
REQ-005 SHALL have parameter down_credits, default 4, initial downstream credits per VC.
REQ-006 SHALL have a single clock; reset is synchronous and active-high.
REQ-007 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port in_port, input, flit_size, flit from upstream; bit 9 = head, bit 8 = tail.
REQ-010 SHALL have port write, input, 1, in_port valid this cycle.
REQ-011 SHALL have port out_credit, output, num_of_vcs, one-cycle credit-return pulse per VC to upstream.
REQ-012 SHALL have port out_port, output, flit_size, flit to downstream.
REQ-013 SHALL have port out_write, output, 1, out_port valid this cycle.
REQ-014 SHALL have port in_credit, input, num_of_vcs, credit-return pulse per VC from downstream.
REQ-015 SHALL have port overflow, output, 1, sticky error flag.

Function
REQ-016 SHALL write in_port into FIFO v = in_port[vcs_size-1:0] at the edge where write=1.
REQ-017 SHALL drop the flit and set overflow=1 (sticky until rst) on a write to a full FIFO, or when v >= num_of_vcs.
REQ-018 SHALL keep one credit counter per VC, width buffer_addr_w+1 at minimum, initialised to down_credits.
REQ-019 SHALL mark VC v eligible when FIFO v is non-empty and credit[v] > 0.
REQ-020 SHALL run an arbiter FSM with states IDLE and LOCKED(v).
REQ-021 In IDLE, SHALL pick one eligible VC per cycle by round-robin, starting from rr_ptr.
REQ-022 After a grant to v, SHALL set rr_ptr to v+1 mod num_of_vcs.
REQ-023 On a grant, SHALL register out_port = FIFO v head, out_write=1, pop FIFO v, decrement credit[v], and drive out_credit[v]=1 for exactly that cycle.
REQ-024 A granted head flit with tail=0 SHALL move the FSM to LOCKED(v).
REQ-025 In LOCKED(v), SHALL serve only VC v, stalling while v is ineligible; no other VC is granted.
REQ-026 Sending a flit with tail=1 SHALL return the FSM to IDLE; a head+tail flit keeps IDLE.
REQ-027 SHALL hold out_write=0 and out_credit=0 in cycles with no grant; out_port holds its last value.
REQ-028 Minimum latency SHALL be write at edge N -> out_write=1 after edge N+1.
REQ-029 A write and a pop on the same FIFO in one cycle SHALL both take effect, including when the FIFO is full.
REQ-030 in_credit[v]=1 SHALL increment credit[v]; with a simultaneous decrement the net change is zero.
REQ-031 SHALL saturate credit[v] at down_credits.
REQ-032 FIFO pointers SHALL wrap modulo depth; full/empty SHALL use an occupancy count or an extra pointer bit.

Reset
REQ-033 At a rising edge with rst=1, SHALL clear all FIFOs, set credits to down_credits, rr_ptr=0, FSM=IDLE, out_port=0, out_write=0, out_credit=0, overflow=0.
REQ-034 Reset mid-packet SHALL discard buffered flits, exit LOCKED, and issue no credit pulses for discarded flits.
REQ-035 SHALL ignore write and in_credit during cycles with rst=1.

Verification
REQ-036 Single flit VC0 head+tail, edge 1 -> out_write=1 and out_credit=01 after edge 2; FSM stays IDLE.
REQ-037 VC0 and VC1 single-flit packets written, both pending -> grants alternate VC0, VC1, VC0; rr_ptr wraps to 0.
REQ-038 VC0 3-flit packet (head, body, tail), VC1 flits pending, VC0 body delayed 3 cycles -> VC1 not granted until VC0 tail sent.
REQ-039 5 writes to VC1 with no pops (credit[1]=0) -> 4 stored, overflow=1; after 4 in_credit[1] pulses, 4 flits drain in order.
REQ-040 down_credits=1, in_credit[0] pulse in same cycle as VC0 grant -> credit[0] stays 1, back-to-back grants continue.
REQ-041 rst asserted while LOCKED with 2 flits buffered -> next cycle out_write=0, out_credit=0, overflow=0, FIFOs empty, credits=down_credits.
